base_aelastic: RTL and testbench

// - Two-entry elastic buffer for a valid/ready stream, carrying data.
// - Registers both directions: dout_v/dout_d forward and din_r backward come only from flops.
// - Counterpart of the burp control. That block registers only the ready path; this one

---
 rtl/base_aelastic.sv | 90 +++++++++
 tb/tb_base_aelastic.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/base_aelastic.sv
// Two-entry elastic buffer with fully registered valid/ready/data paths.
// Optional stall counter enabled by defining BASE_AELASTIC_STATS_EN.
module base_aelastic #(
    parameter int width = 8,
    parameter int cntw  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_v,
    output logic             din_r,
    input  logic [width-1:0] din_d,
    output logic             dout_v,
    input  logic             dout_r,
    output logic [width-1:0] dout_d,
    output logic [cntw-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [width-1:0] h0;
    logic [width-1:0] h1;
    logic             accept;
    logic             take;

    // Handshake outputs decode the state flops only; no input reaches them.
    assign dout_v = (state != EMPTY);
    assign din_r  = (state != TWO);
    assign dout_d = h0;

    assign accept = din_v & din_r;
    assign take   = dout_v & dout_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            h0    <= '0;
            h1    <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        h0    <= din_d;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        h0 <= din_d;
                    end else if (accept) begin
                        h1    <= din_d;
                        state <= TWO;
                    end else if (take) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // The skid entry moves to the head; din_r is low here.
                    if (take) begin
                        h0    <= h1;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef BASE_AELASTIC_STATS_EN
    logic [cntw-1:0] cnt;

    // Saturating count of cycles where a beat is offered but not taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (dout_v && !dout_r && (cnt != {cntw{1'b1}})) begin
            cnt <= cnt + cntw'(1);
        end
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_base_aelastic.sv
// Self-checking bench for base_aelastic: vector table, scoreboard, reset and stats cases.
module tb_base_aelastic;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk;
    logic         reset;
    logic         din_v;
    logic         din_r;
    logic [W-1:0] din_d;
    logic         dout_v;
    logic         dout_r;
    logic [W-1:0] dout_d;
    logic [C-1:0] stall_cnt;

    int n_checks;
    int n_pass;

    logic [W-1:0] q[$];

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         e_dv;
        logic         e_dr;
        logic [W-1:0] e_dd;
    } vec_t;

    vec_t tbl[19];

    base_aelastic #(.width(W), .cntw(C)) dut (
        .clk      (clk),
        .reset    (reset),
        .din_v    (din_v),
        .din_r    (din_r),
        .din_d    (din_d),
        .dout_v   (dout_v),
        .dout_r   (dout_r),
        .dout_d   (dout_d),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic v, input logic [W-1:0] d,
                                input logic r, input logic e_dv,
                                input logic e_dr, input logic [W-1:0] e_dd);
        vec_t t;
        t.v = v; t.d = d; t.r = r;
        t.e_dv = e_dv; t.e_dr = e_dr; t.e_dd = e_dd;
        return t;
    endfunction

    // One cycle: check outputs against the model, drive inputs, advance model.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        logic tk;
        logic ac;
        @(negedge clk);
        chk("sb_dout_v", 32'(dout_v), 32'(q.size() > 0));
        chk("sb_din_r", 32'(din_r), 32'(q.size() < 2));
        if (q.size() > 0) chk("sb_dout_d", 32'(dout_d), 32'(q[0]));
        din_v  = v;
        din_d  = d;
        dout_r = r;
        tk = r && (q.size() > 0);
        ac = v && (q.size() < 2);
        if (tk) void'(q.pop_front());
        if (ac) q.push_back(d);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_dout_v"}, 32'(dout_v), 32'd0);
        chk({tag, "_din_r"}, 32'(din_r), 32'd1);
        chk({tag, "_dout_d"}, 32'(dout_d), 32'd0);
        chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        din_v    = 1'b0;
        din_d    = '0;
        dout_r   = 1'b0;
        reset    = 1'b1;
        #3;
        chk_reset_outs("por");
        @(negedge clk);
        din_v = 1'b1;
        din_d = 8'hEE;
        @(negedge clk);
        chk("por_ignore_din", 32'(dout_v), 32'd0);
        din_v = 1'b0;
        reset = 1'b0;

        // Stream 1..8, then backpressure from the third beat of a second burst.
        tbl[0]  = mk(1, 8'h01, 1, 0, 1, 8'h00);
        for (int i = 1; i < 8; i++)
            tbl[i] = mk(1, 8'(i + 1), 1, 1, 1, 8'(i));
        tbl[8]  = mk(0, 8'h00, 1, 1, 1, 8'h08);
        tbl[9]  = mk(0, 8'h00, 0, 0, 1, 8'h08);
        tbl[10] = mk(1, 8'h11, 1, 0, 1, 8'h08);
        tbl[11] = mk(1, 8'h12, 1, 1, 1, 8'h11);
        tbl[12] = mk(1, 8'h13, 0, 1, 1, 8'h12);
        tbl[13] = mk(1, 8'h14, 0, 1, 0, 8'h12);
        tbl[14] = mk(1, 8'h14, 0, 1, 0, 8'h12);
        tbl[15] = mk(1, 8'h14, 1, 1, 0, 8'h12);
        tbl[16] = mk(1, 8'h14, 1, 1, 1, 8'h13);
        tbl[17] = mk(0, 8'h00, 1, 1, 1, 8'h14);
        tbl[18] = mk(0, 8'h00, 0, 0, 1, 8'h14);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_dout_v", i), 32'(dout_v), 32'(tbl[i].e_dv));
            chk($sformatf("tbl%0d_din_r", i), 32'(din_r), 32'(tbl[i].e_dr));
            chk($sformatf("tbl%0d_dout_d", i), 32'(dout_d), 32'(tbl[i].e_dd));
            din_v  = tbl[i].v;
            din_d  = tbl[i].d;
            dout_r = tbl[i].r;
        end

        // Random traffic against the scoreboard.
        q.delete();
        for (int i = 0; i < 3000; i++)
            step(1'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < 4; i++)
            step(1'b0, 8'h00, 1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);

        // Fill to TWO, then reset mid-cycle.
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("two_full", 32'(din_r), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outs("mid");
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        step(1'b1, 8'h77, 1'b1);
        step(1'b1, 8'h78, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Stall counter: one beat held with dout_r low for 20+ cycles.
        step(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 22; i++) begin
            if (i >= 1) begin
`ifdef BASE_AELASTIC_STATS_EN
                chk($sformatf("stall%0d", i), 32'(stall_cnt),
                    32'((i - 1) > 15 ? 15 : (i - 1)));
`else
                chk($sformatf("stall%0d", i), 32'(stall_cnt), 32'd0);
`endif
            end
            step(1'b0, 8'h00, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
